// File: rtl/i2c_slave_serial_fsm.sv
// Bit-level I2C slave engine: START/STOP decode, address match, register write/read serialisation.
// Define I2C_ADDR_AUTOINC_EN to advance regAddr after each written byte and each master-ACKed read byte.
module i2c_slave_serial_fsm #(
  parameter logic [6:0] DEV_ADDR = 7'h3C
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclIn,
  input  logic       sdaIn,
  output logic       sdaOut,
  output logic [7:0] regAddr,
  output logic [7:0] regWrData,
  output logic       regWriteEn,
  input  logic [7:0] regRdData,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_ADDR,
    S_DEV_ACK,
    S_REG_ADDR,
    S_REG_ACK,
    S_WRITE_DATA,
    S_WRITE_ACK,
    S_READ_DATA,
    S_READ_ACK,
    S_WAIT_STOP
  } state_t;

  state_t      r_state;
  logic        r_scl_d;
  logic        r_sda_d;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_rw;
  logic        r_full;

  logic        w_scl_rise;
  logic        w_scl_fall;
  logic        w_start;
  logic        w_stop;
  logic        w_byte_end;
  logic        w_rx_state;

  assign w_scl_rise = sclIn & ~r_scl_d;
  assign w_scl_fall = ~sclIn & r_scl_d;
  assign w_start    = sclIn & r_scl_d & r_sda_d & ~sdaIn;
  assign w_stop     = sclIn & r_scl_d & ~r_sda_d & sdaIn;
  // r_full marks that all 8 bits of the current byte have been sampled
  assign w_byte_end = w_scl_fall & r_full;
  assign w_rx_state = (r_state == S_DEV_ADDR) || (r_state == S_REG_ADDR) ||
                      (r_state == S_WRITE_DATA);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_rw       <= 1'b0;
      r_full     <= 1'b0;
      sdaOut     <= 1'b1;
      regAddr    <= 8'd0;
      regWrData  <= 8'd0;
      regWriteEn <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_scl_d    <= sclIn;
      r_sda_d    <= sdaIn;
      regWriteEn <= 1'b0;
`ifdef I2C_ADDR_AUTOINC_EN
      if (regWriteEn) regAddr <= regAddr + 8'd1;
`endif
      if (w_start) begin
        r_state   <= S_DEV_ADDR;
        r_bit_cnt <= 3'd0;
        r_full    <= 1'b0;
        sdaOut    <= 1'b1;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_full  <= 1'b0;
        sdaOut  <= 1'b1;
        busy    <= 1'b0;
      end else begin
        if (w_rx_state && w_scl_rise) begin
          r_shift   <= {r_shift[6:0], sdaIn};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_full <= 1'b1;
        end
        case (r_state)
          S_DEV_ADDR: if (w_byte_end) begin
            r_full <= 1'b0;
            if (r_shift[7:1] == DEV_ADDR) begin
              sdaOut  <= 1'b0;
              busy    <= 1'b1;
              r_rw    <= r_shift[0];
              r_state <= S_DEV_ACK;
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_DEV_ACK: if (w_scl_fall) begin
            r_bit_cnt <= 3'd0;
            if (r_rw) begin
              r_shift <= regRdData;
              sdaOut  <= regRdData[7];
              r_state <= S_READ_DATA;
            end else begin
              sdaOut  <= 1'b1;
              r_state <= S_REG_ADDR;
            end
          end
          S_REG_ADDR: if (w_byte_end) begin
            r_full  <= 1'b0;
            regAddr <= r_shift;
            sdaOut  <= 1'b0;
            r_state <= S_REG_ACK;
          end
          S_REG_ACK: if (w_scl_fall) begin
            sdaOut  <= 1'b1;
            r_state <= S_WRITE_DATA;
          end
          S_WRITE_DATA: if (w_byte_end) begin
            r_full     <= 1'b0;
            regWrData  <= r_shift;
            regWriteEn <= 1'b1;
            sdaOut     <= 1'b0;
            r_state    <= S_WRITE_ACK;
          end
          S_WRITE_ACK: if (w_scl_fall) begin
            sdaOut  <= 1'b1;
            r_state <= S_WRITE_DATA;
          end
          S_READ_DATA: if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
              sdaOut    <= 1'b1;
              r_bit_cnt <= 3'd0;
              r_state   <= S_READ_ACK;
            end else begin
              sdaOut    <= r_shift[6];
              r_shift   <= {r_shift[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          S_READ_ACK: begin
            if (w_scl_rise) begin
              if (sdaIn) begin
                r_state <= S_WAIT_STOP;
              end else begin
                r_full <= 1'b1;
`ifdef I2C_ADDR_AUTOINC_EN
                regAddr <= regAddr + 8'd1;
`endif
              end
            end else if (w_byte_end) begin
              r_full    <= 1'b0;
              r_shift   <= regRdData;
              sdaOut    <= regRdData[7];
              r_bit_cnt <= 3'd0;
              r_state   <= S_READ_DATA;
            end
          end
          S_IDLE, S_WAIT_STOP: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_serial_fsm.sv
// Directed bench for i2c_slave_serial_fsm: bit-banged I2C master, scoreboard queues, write-strobe monitor.
module tb_i2c_slave_serial_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sdaOut;
  logic [7:0] regAddr;
  logic [7:0] regWrData;
  logic       regWriteEn;
  logic [7:0] regRdData = 8'd0;
  logic       busy;

  int checks = 0;
  int errors = 0;

  string      tag_q[$];
  logic [7:0] val_q[$];
  logic [7:0] wr_a_q[$];
  logic [7:0] wr_d_q[$];
  logic       prev_we = 1'b0;
  logic       watch_en = 1'b0;
  logic       saw_low = 1'b0;

  assign sda_bus = m_sda & sdaOut;

  always #5 clk = ~clk;

  // Register file model: read data follows regAddr by one clock
  always @(posedge clk) regRdData <= (regAddr == 8'h05) ? 8'h5A : (regAddr ^ 8'hFF);

  i2c_slave_serial_fsm #(.DEV_ADDR(7'h3C)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclIn      (scl),
    .sdaIn      (sda_bus),
    .sdaOut     (sdaOut),
    .regAddr    (regAddr),
    .regWrData  (regWrData),
    .regWriteEn (regWriteEn),
    .regRdData  (regRdData),
    .busy       (busy)
  );

  task automatic push(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    val_q.push_back(v);
  endtask

  task automatic pop_chk(input logic [7:0] obs);
    string      tag;
    logic [7:0] ev;
    checks++;
    assert (val_q.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=queued_entry", obs);
    end
    if (val_q.size() != 0) begin
      tag = tag_q.pop_front();
      ev  = val_q.pop_front();
      assert (obs === ev) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, ev);
      end
      $display("check %s observed=%0h expected=%0h", tag, obs, ev);
    end
  endtask

  task automatic on_write();
    logic [7:0] ea;
    logic [7:0] ed;
    checks++;
    assert (prev_we === 1'b0) else begin
      errors++;
      $error("FAIL we_width observed=multi_cycle expected=single_cycle");
    end
    checks++;
    assert (wr_a_q.size() != 0) else begin
      errors++;
      $error("FAIL wr_unexpected observed=addr %0h data %0h expected=no_write", regAddr, regWrData);
    end
    if (wr_a_q.size() != 0) begin
      ea = wr_a_q.pop_front();
      ed = wr_d_q.pop_front();
      checks++;
      assert (regAddr === ea) else begin
        errors++;
        $error("FAIL wr_addr observed=%0h expected=%0h", regAddr, ea);
      end
      checks++;
      assert (regWrData === ed) else begin
        errors++;
        $error("FAIL wr_data observed=%0h expected=%0h", regWrData, ed);
      end
      $display("write addr=%0h data=%0h expected addr=%0h data=%0h", regAddr, regWrData, ea, ed);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (regWriteEn === 1'b1) on_write();
      if (watch_en && sdaOut !== 1'b1) saw_low = 1'b1;
      prev_we = regWriteEn;
    end
  endtask

  task automatic start_cond();
    m_sda = 1'b1; tick(4);
    scl   = 1'b1; tick(4);
    m_sda = 1'b0; tick(4);
    scl   = 1'b0; tick(4);
  endtask

  task automatic stop_cond();
    m_sda = 1'b0; tick(4);
    scl   = 1'b1; tick(4);
    m_sda = 1'b1; tick(4);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; tick(4);
    scl   = 1'b1; tick(8);
    scl   = 1'b0; tick(4);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack, input string tag);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    push(tag, {7'd0, exp_ack});
    m_sda = 1'b1; tick(4);
    scl   = 1'b1; tick(4);
    pop_chk({7'd0, sda_bus});
    tick(4);
    scl   = 1'b0; tick(4);
  endtask

  task automatic read_byte(input logic [7:0] d, input logic m_ack);
    for (int i = 7; i >= 0; i--) begin
      push($sformatf("rd_bit%0d", i), {7'd0, d[i]});
      m_sda = 1'b1; tick(4);
      scl   = 1'b1; tick(4);
      pop_chk({7'd0, sda_bus});
      tick(4);
      scl   = 1'b0; tick(4);
    end
    m_sda = m_ack; tick(4);
    scl   = 1'b1; tick(8);
    scl   = 1'b0; tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=no_finish expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick(3);
    push("reset_sda", 8'd1);   pop_chk({7'd0, sdaOut});
    push("reset_busy", 8'd0);  pop_chk({7'd0, busy});
    push("reset_addr", 8'd0);  pop_chk(regAddr);
    push("reset_wdata", 8'd0); pop_chk(regWrData);
    push("reset_we", 8'd0);    pop_chk({7'd0, regWriteEn});
    rst = 1'b0;
    tick(4);

    // Single write 0x3C+W, reg 0x02, data 0xA5
    start_cond();
    send_byte(8'h78, 1'b0, "t1_dev_ack");
    push("t1_busy_high", 8'd1); pop_chk({7'd0, busy});
    send_byte(8'h02, 1'b0, "t1_reg_ack");
    wr_a_q.push_back(8'h02); wr_d_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b0, "t1_data_ack");
    stop_cond();
    push("t1_busy_low", 8'd0); pop_chk({7'd0, busy});
    push("t1_wr_done", 8'd0);  pop_chk(8'(wr_a_q.size()));

    // Address mismatch 0x3D+W: no ACK anywhere, then idle
    saw_low = 1'b0; watch_en = 1'b1;
    start_cond();
    send_byte(8'h7A, 1'b1, "t2_dev_nack");
    send_byte(8'h02, 1'b1, "t2_idle_nack");
    stop_cond();
    watch_en = 1'b0;
    push("t2_sda_held", 8'd0); pop_chk({7'd0, saw_low});
    push("t2_busy", 8'd0);     pop_chk({7'd0, busy});

    // Write-address then repeated START read of reg 0x05
    start_cond();
    send_byte(8'h78, 1'b0, "t3_dev_ack");
    send_byte(8'h05, 1'b0, "t3_reg_ack");
    start_cond();
    send_byte(8'h79, 1'b0, "t3_rd_dev_ack");
    push("t3_regaddr", 8'h05); pop_chk(regAddr);
    read_byte(8'h5A, 1'b1);
    saw_low = 1'b0; watch_en = 1'b1;
    send_bit(1'b0);
    watch_en = 1'b0;
    push("t3_released", 8'd0); pop_chk({7'd0, saw_low});
    stop_cond();
    push("t3_busy", 8'd0); pop_chk({7'd0, busy});

    // Burst write at reg 0xFF
    start_cond();
    send_byte(8'h78, 1'b0, "t4_dev_ack");
    send_byte(8'hFF, 1'b0, "t4_reg_ack");
    wr_a_q.push_back(8'hFF); wr_d_q.push_back(8'h11);
    send_byte(8'h11, 1'b0, "t4_d0_ack");
`ifdef I2C_ADDR_AUTOINC_EN
    wr_a_q.push_back(8'h00);
`else
    wr_a_q.push_back(8'hFF);
`endif
    wr_d_q.push_back(8'h22);
    send_byte(8'h22, 1'b0, "t4_d1_ack");
    stop_cond();
    push("t4_wr_done", 8'd0); pop_chk(8'(wr_a_q.size()));

    // STOP after 4 data bits: no write, regWrData unchanged, back in IDLE
    start_cond();
    send_byte(8'h78, 1'b0, "t6_dev_ack");
    send_byte(8'h02, 1'b0, "t6_reg_ack");
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    stop_cond();
    push("t6_wdata", 8'h22); pop_chk(regWrData);
    push("t6_busy", 8'd0);   pop_chk({7'd0, busy});
    scl = 1'b0; tick(4);
    saw_low = 1'b0; watch_en = 1'b1;
    send_byte(8'h78, 1'b1, "t6_idle_nack");
    watch_en = 1'b0;
    push("t6_sda_held", 8'd0); pop_chk({7'd0, saw_low});
    stop_cond();

    // Reset while ACKing the device address
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : (i >= 3 && i <= 6));
    push("t5_ack_driven", 8'd0); pop_chk({7'd0, sdaOut});
    rst = 1'b1;
    tick(1);
    push("t5_rst_sda", 8'd1);   pop_chk({7'd0, sdaOut});
    push("t5_rst_busy", 8'd0);  pop_chk({7'd0, busy});
    push("t5_rst_addr", 8'd0);  pop_chk(regAddr);
    push("t5_rst_wdata", 8'd0); pop_chk(regWrData);
    push("t5_rst_we", 8'd0);    pop_chk({7'd0, regWriteEn});
    rst = 1'b0;
    m_sda = 1'b1; tick(3);
    scl = 1'b1; tick(8);
    scl = 1'b0; tick(4);
    start_cond();
    send_byte(8'h78, 1'b0, "t5_ack_after_rst");
    stop_cond();
    push("t5_busy", 8'd0); pop_chk({7'd0, busy});

    push("wr_all_consumed", 8'd0); pop_chk(8'(wr_a_q.size()));
    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
